// File: rtl/sram_2p_arb_pkg.sv
// rtl/sram_2p_arb_pkg.sv - shared widths, response port tags and pointer helper for the dual-port SRAM arbiter
// Purpose : default width constants, the per-requester response tag encoding,
//           and the round-robin pointer increment used by the arbiter.
package sram_2p_arb_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 9;
  localparam int DEF_NUM_REQ    = 4;

  // Which SRAM port (if any) carries a requester's read data next cycle.
  typedef enum logic [1:0] {
    NONE   = 2'd0,
    PORT_A = 2'd1,
    PORT_B = 2'd2
  } port_tag_e;

  // (idx + 1) mod n without a divider.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/sram_2p_rr_pick.sv
// rtl/sram_2p_rr_pick.sv - round-robin first-eligible finder starting at a pointer
// Purpose : scan i_mask from i_ptr upward (wrapping at P_N) and report the
//           first set position.
// Ports   : i_ptr   - scan start index
//           i_mask  - eligible requesters
//           o_found - at least one eligible requester
//           o_idx   - index of the first eligible requester (0 when none)
module sram_2p_rr_pick #(
  parameter int P_N  = 4,
  parameter int P_PW = 2
) (
  input  logic [P_PW-1:0] i_ptr,
  input  logic [P_N-1:0]  i_mask,
  output logic            o_found,
  output logic [P_PW-1:0] o_idx
);

  int w_pos;

  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    w_pos   = 0;
    for (int k = 0; k < P_N; k++) begin
      w_pos = int'(i_ptr) + k;
      if (w_pos >= P_N) begin
        w_pos = w_pos - P_N;
      end
      if (!o_found && i_mask[w_pos[P_PW-1:0]]) begin
        o_found = 1'b1;
        o_idx   = w_pos[P_PW-1:0];
      end
    end
  end

endmodule

// File: rtl/sram_2p_arbiter.sv
// rtl/sram_2p_arbiter.sv - round-robin arbiter granting up to two requesters per cycle onto a 2-port SRAM
// Purpose : picks the first eligible requester for port A and the next
//           non-conflicting one for port B, drives the SRAM commands
//           combinationally and routes 1-cycle read data back to requesters.
// Ports   : i_clk, i_rst           - clock, synchronous active-high reset
//           i_en                   - arbitration enable
//           i_req_* / o_req_ready  - packed requester command interface
//           o_rsp_valid/o_rsp_rdata- packed read responses
//           o_a_* / i_a_dout       - SRAM port A command and read data
//           o_b_* / i_b_dout       - SRAM port B command and read data
module sram_2p_arbiter
  import sram_2p_arb_pkg::*;
#(
  parameter int P_DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int P_ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int P_NUM_REQ    = DEF_NUM_REQ
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic                              i_en,
  input  logic [P_NUM_REQ-1:0]              i_req_valid,
  output logic [P_NUM_REQ-1:0]              o_req_ready,
  input  logic [P_NUM_REQ-1:0]              i_req_we,
  input  logic [P_NUM_REQ*P_ADDR_WIDTH-1:0] i_req_addr,
  input  logic [P_NUM_REQ*P_DATA_WIDTH-1:0] i_req_wdata,
  output logic [P_NUM_REQ-1:0]              o_rsp_valid,
  output logic [P_NUM_REQ*P_DATA_WIDTH-1:0] o_rsp_rdata,
  output logic                              o_a_men,
  output logic                              o_a_wen,
  output logic                              o_a_ren,
  output logic [P_ADDR_WIDTH-1:0]           o_a_addr,
  output logic [P_DATA_WIDTH-1:0]           o_a_din,
  input  logic [P_DATA_WIDTH-1:0]           i_a_dout,
  output logic                              o_b_men,
  output logic                              o_b_wen,
  output logic                              o_b_ren,
  output logic [P_ADDR_WIDTH-1:0]           o_b_addr,
  output logic [P_DATA_WIDTH-1:0]           o_b_din,
  input  logic [P_DATA_WIDTH-1:0]           i_b_dout
);

  localparam int LP_PW = $clog2(P_NUM_REQ);

  logic [LP_PW-1:0]        r_ptr;
  port_tag_e               r_tag   [P_NUM_REQ];
  logic [P_DATA_WIDTH-1:0] r_rdata [P_NUM_REQ];

  logic [P_ADDR_WIDTH-1:0] w_addr     [P_NUM_REQ];
  logic [P_DATA_WIDTH-1:0] w_wdata    [P_NUM_REQ];
  logic [P_DATA_WIDTH-1:0] w_rsp_data [P_NUM_REQ];
  logic [P_NUM_REQ-1:0]    w_elig;
  logic [P_NUM_REQ-1:0]    w_b_elig;
  logic [P_NUM_REQ-1:0]    w_gnt_a;
  logic [P_NUM_REQ-1:0]    w_gnt_b;
  logic                    w_a_found;
  logic                    w_b_found;
  logic [LP_PW-1:0]        w_a_idx;
  logic [LP_PW-1:0]        w_b_idx;
  logic [LP_PW-1:0]        w_ptr_next;

  for (genvar g = 0; g < P_NUM_REQ; g++) begin : g_unpack
    assign w_addr[g]  = i_req_addr[g*P_ADDR_WIDTH +: P_ADDR_WIDTH];
    assign w_wdata[g] = i_req_wdata[g*P_DATA_WIDTH +: P_DATA_WIDTH];
  end

  assign w_elig = i_req_valid & {P_NUM_REQ{i_en & ~i_rst}};

  sram_2p_rr_pick #(.P_N(P_NUM_REQ), .P_PW(LP_PW)) u_pick_a (
    .i_ptr   (r_ptr),
    .i_mask  (w_elig),
    .o_found (w_a_found),
    .o_idx   (w_a_idx)
  );

  // Port B may not reuse the port-A requester, nor touch the same address
  // when either side writes. Scanning from the same pointer is equivalent to
  // continuing after A, since everything before A is already ineligible.
  always_comb begin
    w_b_elig = w_elig;
    for (int i = 0; i < P_NUM_REQ; i++) begin
      if (w_a_found) begin
        if (LP_PW'(i) == w_a_idx) begin
          w_b_elig[i] = 1'b0;
        end else if ((w_addr[i] == w_addr[w_a_idx]) && (i_req_we[i] || i_req_we[w_a_idx])) begin
          w_b_elig[i] = 1'b0;
        end
      end
    end
  end

  sram_2p_rr_pick #(.P_N(P_NUM_REQ), .P_PW(LP_PW)) u_pick_b (
    .i_ptr   (r_ptr),
    .i_mask  (w_b_elig),
    .o_found (w_b_found),
    .o_idx   (w_b_idx)
  );

  always_comb begin
    w_gnt_a  = '0;
    w_gnt_b  = '0;
    o_a_men  = 1'b0;
    o_a_wen  = 1'b0;
    o_a_ren  = 1'b0;
    o_a_addr = '0;
    o_a_din  = '0;
    o_b_men  = 1'b0;
    o_b_wen  = 1'b0;
    o_b_ren  = 1'b0;
    o_b_addr = '0;
    o_b_din  = '0;
    if (w_a_found) begin
      w_gnt_a[w_a_idx] = 1'b1;
      o_a_men  = 1'b1;
      o_a_wen  = i_req_we[w_a_idx];
      o_a_ren  = ~i_req_we[w_a_idx];
      o_a_addr = w_addr[w_a_idx];
      o_a_din  = i_req_we[w_a_idx] ? w_wdata[w_a_idx] : '0;
    end
    if (w_b_found) begin
      w_gnt_b[w_b_idx] = 1'b1;
      o_b_men  = 1'b1;
      o_b_wen  = i_req_we[w_b_idx];
      o_b_ren  = ~i_req_we[w_b_idx];
      o_b_addr = w_addr[w_b_idx];
      o_b_din  = i_req_we[w_b_idx] ? w_wdata[w_b_idx] : '0;
    end
    o_req_ready = w_gnt_a | w_gnt_b;

    // B always lies after A in scan order, so it is the last grant when present.
    w_ptr_next = r_ptr;
    if (w_b_found) begin
      w_ptr_next = LP_PW'(rr_next(int'(w_b_idx), P_NUM_REQ));
    end else if (w_a_found) begin
      w_ptr_next = LP_PW'(rr_next(int'(w_a_idx), P_NUM_REQ));
    end
  end

  // Read data arrives straight from the SRAM in the cycle after the grant;
  // the registered copy holds the slice steady between responses.
  always_comb begin
    o_rsp_valid = '0;
    o_rsp_rdata = '0;
    for (int i = 0; i < P_NUM_REQ; i++) begin
      w_rsp_data[i]  = (r_tag[i] == PORT_B) ? i_b_dout : i_a_dout;
      o_rsp_valid[i] = (r_tag[i] != NONE) && !i_rst;
      o_rsp_rdata[i*P_DATA_WIDTH +: P_DATA_WIDTH] = o_rsp_valid[i] ? w_rsp_data[i] : r_rdata[i];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr <= '0;
      for (int i = 0; i < P_NUM_REQ; i++) begin
        r_tag[i]   <= NONE;
        r_rdata[i] <= '0;
      end
    end else begin
      r_ptr <= w_ptr_next;
      for (int i = 0; i < P_NUM_REQ; i++) begin
        if (o_rsp_valid[i]) begin
          r_rdata[i] <= w_rsp_data[i];
        end
        if (w_gnt_a[i] && !i_req_we[i]) begin
          r_tag[i] <= PORT_A;
        end else if (w_gnt_b[i] && !i_req_we[i]) begin
          r_tag[i] <= PORT_B;
        end else begin
          r_tag[i] <= NONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_sram_2p_arbiter.sv
// tb/tb_sram_2p_arbiter.sv - table-driven self-checking bench for sram_2p_arbiter with a response scoreboard
module tb_sram_2p_arbiter;

  logic         clk;
  logic         rst;
  logic         en;
  logic [3:0]   valid;
  logic [3:0]   ready;
  logic [3:0]   we;
  logic [35:0]  addr;
  logic [127:0] wdata;
  logic [3:0]   rsp_valid;
  logic [127:0] rsp_rdata;
  logic         a_men, a_wen, a_ren, b_men, b_wen, b_ren;
  logic [8:0]   a_addr, b_addr;
  logic [31:0]  a_din, b_din, a_dout, b_dout;

  typedef struct {
    string        name;
    logic         rst;
    logic         en;
    logic [3:0]   valid;
    logic [3:0]   we;
    logic [35:0]  addr;
    logic [127:0] wdata;
    logic [3:0]   exp_ready;
    logic [2:0]   ea;
    logic [2:0]   eb;
  } vec_t;

  typedef struct {
    int          cyc;
    int          idx;
    logic [31:0] data;
  } rsp_t;

  localparam logic [2:0] NG = 3'b000;
  localparam logic [2:0] G0 = 3'b100;
  localparam logic [2:0] G1 = 3'b101;
  localparam logic [2:0] G2 = 3'b110;
  localparam logic [2:0] G3 = 3'b111;
  localparam logic [35:0] AD_SEQ = {9'h13, 9'h12, 9'h11, 9'h10};
  localparam logic [35:0] AD_2   = {9'h33, 9'h32, 9'h31, 9'h30};
  localparam logic [35:0] AD_F   = {9'h43, 9'h42, 9'h41, 9'h40};

  logic [31:0]  mem    [512];
  logic [31:0]  shadow [512];
  rsp_t         sb [$];
  vec_t         tbl [$];
  logic [127:0] exp_last;
  bit           rd_known;
  logic [3:0]   smp_ready;
  int           cyc;
  int           n_chk;
  int           n_pass;

  sram_2p_arbiter dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_en        (en),
    .i_req_valid (valid),
    .o_req_ready (ready),
    .i_req_we    (we),
    .i_req_addr  (addr),
    .i_req_wdata (wdata),
    .o_rsp_valid (rsp_valid),
    .o_rsp_rdata (rsp_rdata),
    .o_a_men     (a_men),
    .o_a_wen     (a_wen),
    .o_a_ren     (a_ren),
    .o_a_addr    (a_addr),
    .o_a_din     (a_din),
    .i_a_dout    (a_dout),
    .o_b_men     (b_men),
    .o_b_wen     (b_wen),
    .o_b_ren     (b_ren),
    .o_b_addr    (b_addr),
    .o_b_din     (b_din),
    .i_b_dout    (b_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Two-port synchronous SRAM with 1-cycle read latency.
  always @(posedge clk) begin
    if (a_men && a_wen) mem[a_addr] = a_din;
    if (b_men && b_wen) mem[b_addr] = b_din;
    if (a_men && a_ren) a_dout <= mem[a_addr];
    if (b_men && b_ren) b_dout <= mem[b_addr];
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic vec_t mk(input string name, input logic r, input logic e,
                              input logic [3:0] vl, input logic [3:0] w,
                              input logic [35:0] ad, input logic [127:0] wd,
                              input logic [3:0] rdy, input logic [2:0] ea,
                              input logic [2:0] eb);
    vec_t v;
    v.name = name; v.rst = r; v.en = e; v.valid = vl; v.we = w;
    v.addr = ad; v.wdata = wd; v.exp_ready = rdy; v.ea = ea; v.eb = eb;
    return v;
  endfunction

  function automatic logic [43:0] exp_cmd(input vec_t v, input logic [2:0] g);
    int   idx;
    logic w;
    if (!g[2]) return 44'h0;
    idx = int'(g[1:0]);
    w   = v.we[idx];
    return {1'b1, w, ~w, v.addr[idx*9 +: 9], w ? v.wdata[idx*32 +: 32] : 32'h0};
  endfunction

  task automatic push_grant(input vec_t v, input logic [2:0] g);
    int         idx;
    logic [8:0] ad;
    rsp_t       e;
    if (g[2]) begin
      idx = int'(g[1:0]);
      ad  = v.addr[idx*9 +: 9];
      if (v.we[idx]) begin
        shadow[ad] = v.wdata[idx*32 +: 32];
      end else begin
        e.cyc = cyc; e.idx = idx; e.data = shadow[ad];
        sb.push_back(e);
      end
    end
  endtask

  task automatic apply_row(input vec_t v);
    logic [3:0]   ev;
    logic [127:0] erd;
    rsp_t         e;
    rst = v.rst; en = v.en; valid = v.valid; we = v.we; addr = v.addr; wdata = v.wdata;
    ev  = '0;
    erd = exp_last;
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      e = sb.pop_front();
      if (!v.rst) begin
        ev[e.idx] = 1'b1;
        erd[e.idx*32 +: 32] = e.data;
      end
    end
    @(negedge clk);
    smp_ready = ready;
    chk($sformatf("%s.ready", v.name), 128'(ready), 128'(v.exp_ready));
    chk($sformatf("%s.a_cmd", v.name), 128'({a_men, a_wen, a_ren, a_addr, a_din}), 128'(exp_cmd(v, v.ea)));
    chk($sformatf("%s.b_cmd", v.name), 128'({b_men, b_wen, b_ren, b_addr, b_din}), 128'(exp_cmd(v, v.eb)));
    chk($sformatf("%s.rsp_valid", v.name), 128'(rsp_valid), 128'(ev));
    if (rd_known) chk($sformatf("%s.rsp_rdata", v.name), rsp_rdata, erd);
    if (v.rst) begin
      exp_last = '0;
      rd_known = 1'b1;
    end else begin
      exp_last = erd;
    end
    push_grant(v, v.ea);
    push_grant(v, v.eb);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    int   gcnt  [4];
    int   glast [4];
    int   maxgap;
    vec_t v;
    n_chk = 0; n_pass = 0; cyc = 0; rd_known = 1'b0; exp_last = '0;
    rst = 1'b1; en = 1'b0; valid = '0; we = '0; addr = '0; wdata = '0;
    for (int a = 0; a < 512; a++) begin
      mem[a]    = 32'hC0DE_0000 | 32'(a);
      shadow[a] = 32'hC0DE_0000 | 32'(a);
    end

    tbl.push_back(mk("reset_hold",    1, 1, 4'hF,    4'h0,    AD_SEQ, '0, 4'b0000, NG, NG));
    tbl.push_back(mk("rd4_c0",        0, 1, 4'hF,    4'h0,    AD_SEQ, '0, 4'b0011, G0, G1));
    tbl.push_back(mk("rd4_c1",        0, 1, 4'b1100, 4'h0,    AD_SEQ, '0, 4'b1100, G2, G3));
    tbl.push_back(mk("idle_a",        0, 1, 4'h0,    4'h0,    AD_SEQ, '0, 4'b0000, NG, NG));
    tbl.push_back(mk("conflict",      0, 1, 4'b0111, 4'b0001, {9'h0, 9'h10, 9'h55, 9'h55},
                     {96'h0, 32'h0000_DEAD}, 4'b0101, G0, G2));
    tbl.push_back(mk("conflict_retry",0, 1, 4'b0010, 4'h0,    {9'h0, 9'h0, 9'h55, 9'h0}, '0, 4'b0010, G1, NG));
    tbl.push_back(mk("idle_b",        0, 1, 4'h0,    4'h0,    '0, '0, 4'b0000, NG, NG));
    tbl.push_back(mk("rdrd_same",     0, 1, 4'b1010, 4'h0,    {9'h1FF, 9'h0, 9'h1FF, 9'h0}, '0, 4'b1010, G3, G1));
    tbl.push_back(mk("idle_c",        0, 1, 4'h0,    4'h0,    '0, '0, 4'b0000, NG, NG));
    tbl.push_back(mk("wrwr_conflict", 0, 1, 4'b1101, 4'b1100, {9'h20, 9'h20, 9'h0, 9'h21},
                     {32'h2222_2222, 32'h1111_1111, 64'h0}, 4'b0101, G2, G0));
    tbl.push_back(mk("wr_retry",      0, 1, 4'b1000, 4'b1000, {9'h20, 27'h0},
                     {32'h2222_2222, 96'h0}, 4'b1000, G3, NG));
    tbl.push_back(mk("rd_after_wr",   0, 1, 4'b0001, 4'h0,    {27'h0, 9'h20}, '0, 4'b0001, G0, NG));
    tbl.push_back(mk("en_low",        0, 0, 4'hF,    4'h0,    AD_SEQ, '0, 4'b0000, NG, NG));
    tbl.push_back(mk("rd_before_rst", 0, 1, 4'hF,    4'h0,    AD_2,   '0, 4'b0110, G1, G2));
    tbl.push_back(mk("rst_mid",       1, 1, 4'hF,    4'h0,    AD_2,   '0, 4'b0000, NG, NG));
    tbl.push_back(mk("post_rst",      0, 1, 4'hF,    4'h0,    AD_SEQ, '0, 4'b0011, G0, G1));
    tbl.push_back(mk("idle_d",        0, 1, 4'h0,    4'h0,    '0, '0, 4'b0000, NG, NG));

    for (int i = 0; i < tbl.size(); i++) apply_row(tbl[i]);

    // Fairness: all four continuously valid, pointer starts at 2.
    for (int i = 0; i < 4; i++) begin
      gcnt[i]  = 0;
      glast[i] = -1;
    end
    maxgap = 0;
    for (int k = 0; k < 20; k++) begin
      if (k % 2 == 0) v = mk("fair", 0, 1, 4'hF, 4'h0, AD_F, '0, 4'b1100, G2, G3);
      else            v = mk("fair", 0, 1, 4'hF, 4'h0, AD_F, '0, 4'b0011, G0, G1);
      apply_row(v);
      for (int i = 0; i < 4; i++) begin
        if (smp_ready[i]) begin
          if (glast[i] >= 0 && k - glast[i] > maxgap) maxgap = k - glast[i];
          glast[i] = k;
          gcnt[i]++;
        end
      end
    end
    for (int i = 0; i < 4; i++) chk($sformatf("fair_cnt%0d", i), 128'(gcnt[i]), 128'(10));
    chk("fair_maxgap_le2", 128'(maxgap <= 2), 128'(1));

    apply_row(mk("drain", 0, 1, 4'h0, 4'h0, '0, '0, 4'b0000, NG, NG));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sram_2p_arbiter.md
SRAM_2P_ARBITER -- requirements
Module: sram_2p_arbiter

Interface
REQ-001 The block SHALL expose these parameters:
- P_DATA_WIDTH, default 32, word width.
- P_ADDR_WIDTH, default 9, address width.
- P_NUM_REQ, default 4, number of requesters (2..8).
REQ-002 The block SHALL use one clock and a synchronous, active-high reset, with these ports:
- CLK  in  1  single clock; also drives A_CLK/B_CLK of the SRAM externally.
- RST  in  1  synchronous active-high reset.
REQ-003 Control input:
- EN  in  1  arbitration enable; 0 = no new grants.
REQ-004 Requester ports (index i = 0..P_NUM_REQ-1):
- REQ_VALID  in  P_NUM_REQ  request pending.
- REQ_READY  out  P_NUM_REQ  grant; a transfer occurs when VALID and READY are both high.
- REQ_WE  in  P_NUM_REQ  1 = write, 0 = read.
- REQ_ADDR  in  P_NUM_REQ*P_ADDR_WIDTH  packed addresses.
- REQ_WDATA  in  P_NUM_REQ*P_DATA_WIDTH  packed write data.
REQ-005 Response ports:
- RSP_VALID  out  P_NUM_REQ  read data valid.
- RSP_RDATA  out  P_NUM_REQ*P_DATA_WIDTH  packed read data.
REQ-006 SRAM port A signals, mirrored for port B:
- A_MEN  out  1
- A_WEN  out  1
- A_REN  out  1
- A_ADDR  out  P_ADDR_WIDTH
- A_DIN  out  P_DATA_WIDTH
- A_DOUT  in  P_DATA_WIDTH
- B_MEN, B_WEN, B_REN, B_ADDR, B_DIN, B_DOUT: same as port A.

Function
REQ-007 Each cycle, the block SHALL grant at most two requests: the first eligible to port A, the second eligible to port B.
REQ-008 Eligible SHALL mean REQ_VALID[i]=1 and EN=1 and RST=0. Search order SHALL be round-robin, starting at pointer PTR and ascending modulo P_NUM_REQ.
REQ-009 The second candidate SHALL be skipped if its address equals the port-A grant address and either request is a write. The search SHALL then continue with the next eligible requester.
REQ-010 A read-read to the same address on both ports SHALL be granted.
REQ-011 REQ_READY and the SRAM command outputs SHALL be combinational from the current cycle's inputs and PTR. The SRAM samples the command on the next CLK rising edge.
REQ-012 For a granted write: xMEN=1, xWEN=1, xREN=0, xADDR=REQ_ADDR[i], xDIN=REQ_WDATA[i].
REQ-013 For a granted read: xMEN=1, xWEN=0, xREN=1, xADDR=REQ_ADDR[i], xDIN=0.
REQ-014 On an idle port: MEN=WEN=REN=0, ADDR=0, DIN=0.
REQ-015 Read latency SHALL be 1 cycle. For a read granted in cycle t:
- RSP_VALID[i]=1 in cycle t+1 only.
- RSP_RDATA slice i SHALL equal the DOUT of the port it used.
- The port/ID tag SHALL be registered at the grant.
REQ-016 RSP_RDATA slices SHALL hold their last value when RSP_VALID is low.
REQ-017 If any grant occurs, PTR SHALL update at the clock edge to (index of last granted requester + 1) mod P_NUM_REQ. Otherwise PTR SHALL hold.
REQ-018 A requester SHALL receive at most one grant per cycle.
REQ-019 With EN=0, no grants SHALL be issued. Responses for reads granted in the previous cycle SHALL still be delivered.
REQ-020 Every requester with VALID held high SHALL be granted within P_NUM_REQ cycles while EN=1.

Reset
REQ-021 While RST=1, these SHALL all be 0: REQ_READY, all SRAM command outputs, and RSP_VALID.
REQ-022 At the edge where RST=1, the block SHALL set PTR=0, clear the response tags, and set RSP_RDATA to 0.
REQ-023 A read granted in the cycle before reset asserts SHALL produce no RSP_VALID.

Structure
REQ-024 Package sram_2p_arb_pkg SHALL hold the default width constants and the port-tag encoding: NONE, PORT_A, PORT_B.
REQ-025 The block SHALL contain one sub-module, sram_2p_rr_pick, a parameterised round-robin first-eligible finder from a pointer with a mask. It SHALL be instantiated twice: for port A, and for port B with the A-grant and conflict mask applied.

Verification
REQ-026 The bench SHALL cover these directed scenarios (P_NUM_REQ=4):
- Reset: RST=1 with all VALID=1 -> READY=0, MEN=0; after release, first grants go to A=req0, B=req1.
- Four reads, PTR=0 -> cycle 0: A=req0, B=req1; cycle 1: A=req2, B=req3. RSP_VALID follows one cycle after each grant, with DOUT routed correctly.
- Conflict: req0 writes 0x55 with 0xDEAD, req1 reads 0x55, req2 reads 0x10 -> B=req2, req1 waits. Next cycle req1 reads 0xDEAD.
- Read-read: req1 and req3 both read 0x1FF -> both granted in the same cycle; both RSP_VALID set next cycle.
- Fairness: req0 to req3 continuously valid for 20 cycles -> each is granted 10 times; no gap exceeds 2 cycles.
- Mid-operation reset/EN: read granted at t, RST=1 at t+1 -> no RSP_VALID. EN=0 -> no MEN, while a pending response still arrives.
